bird_sprite_renderer: RTL and testbench
=======================================

// Module: bird_sprite_renderer
// PURPOSE
//  Overlays the 32x32 bird sprite on the background video stream. Sits between
//  the VGA timing/background path and the final RGB output, and drives the bird
//  ROM's row/col address. Aligns sync and background to the ROM's 1-cycle read
//  latency, keys out transparent texels and flags bird/pipe pixel overlap per frame.
// PARAMETERS
//  SPRITE_SIZE  32       sprite edge in pixels; must match the ROM, power of two
//  KEY_RGB      12'h0F0  ROM colour treated as transparent
//  XW           10       pixel/position coordinate width
// PORTS
//  clk            in   1   pixel clock
//  rst_n          in   1   asynchronous active-low reset
//  pix_x          in   XW  current pixel column from VGA timing
//  pix_y          in   XW  current pixel row from VGA timing
//  video_on       in   1   active-area flag for pix_x/pix_y
//  hsync_in       in   1   horizontal sync, aligned with pix_x
//  vsync_in       in   1   vertical sync, aligned with pix_x
//  frame_start    in   1   1-cycle pulse, first cycle of vertical blank
//  bird_x         in   XW  bird top-left column, from physics block
//  bird_y         in   XW  bird top-left row, from physics block
//  bg_rgb         in   12  background/pipe colour for the current pixel
//  pipe_on        in   1   current pixel belongs to a pipe
//  rom_row        out  5   bird ROM row address (combinational)
//  rom_col        out  5   bird ROM column address (combinational)
//  rom_pixel      in   12  bird ROM data, valid one clk after rom_row/rom_col
//  rgb_out        out  12  composited pixel, 0 outside the active area
//  hsync_out      out  1   hsync_in delayed 2 clk
//  vsync_out      out  1   vsync_in delayed 2 clk
//  collision      out  1   previous frame had >=1 opaque bird pixel on a pipe
// BEHAVIOUR
//  Position latch: bx/by <= bird_x/bird_y on frame_start only; reset 0. Mid-frame
//   changes to bird_x/bird_y have no effect until the next frame_start.
//  Hit test (stage 0, comb): in_box = (pix_x >= bx) && ({1'b0,pix_x} < bx+SIZE)
//   && same for y; sums are XW+1 bits, so no wrap near 1023.
//  rom_col = (pix_x - bx)[4:0], rom_row = (pix_y - by)[4:0]. Outside in_box the
//   value is don't-care.
//  Stage 1 (edge k+1): register in_box, video_on, hsync, vsync, bg_rgb, pipe_on.
//   rom_pixel for pixel k is valid at this stage.
//  Stage 2 (edge k+2): register outputs.
//   rgb_out = !video_on1 ? 0 : (in_box1 && rom_pixel!=KEY_RGB) ? rom_pixel : bg_rgb1.
//   hsync_out = hsync1, vsync_out = vsync1.
//  Latency: 2 clk for every output relative to its pix_x/sync input. Throughput
//   is 1 pixel/clk with no stalls.
//  Collision: hit1 = video_on1 && in_box1 && pipe_on1 && rom_pixel!=KEY_RGB.
//   The sticky flag sets on hit1.
//   On frame_start: collision <= sticky|hit1, and sticky <= hit1, so a hit on
//   that same cycle is never lost. collision holds for one whole frame.
//  Reset (async): rgb_out=0, hsync_out=1, vsync_out=1, collision=0, sticky=0,
//   all pipeline regs 0 except sync regs, which are 1.
//   Reset mid-frame drops in-flight pixels; recovery is clean at the next frame_start.
// TESTING
//  1) bird_x=100,bird_y=200, all ROM=FF0, bg=00F: pixel (100,200) -> rgb_out=FF0
//     2 clk later; (99,200) and (132,200) -> 00F; (131,231) -> FF0.
//  2) ROM texel (0,0)=KEY_RGB: pixel (100,200) -> bg_rgb shown; texel (0,1) opaque -> ROM colour.
//  3) bird_x=1000: pixels 1000..1023 show sprite, no wrap artefact at x=0..7.
//  4) Change bird_x mid-frame: output position unchanged until after next frame_start.
//  5) pipe_on=1 under one opaque bird pixel: collision=1 after next frame_start,
//     back to 0 after the following clean frame. A hit on the frame_start cycle is still reported.
//  6) Assert rst_n=0 mid-line: outputs go to reset values immediately; syncs are
//     delayed exactly 2 clk after release.

Source files
------------

// File: rtl/bird_sprite_renderer.sv
// Composites the bird sprite over the background video, driving the bird ROM
// address and aligning sync/background to the ROM's one-cycle read latency.
module bird_sprite_renderer #(
  parameter int          SPRITE_SIZE = 32,
  parameter logic [11:0] KEY_RGB     = 12'h0F0,
  parameter int          XW          = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [XW-1:0]                  pix_x,
  input  logic [XW-1:0]                  pix_y,
  input  logic                           video_on,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           frame_start,
  input  logic [XW-1:0]                  bird_x,
  input  logic [XW-1:0]                  bird_y,
  input  logic [11:0]                    bg_rgb,
  input  logic                           pipe_on,
  output logic [$clog2(SPRITE_SIZE)-1:0] rom_row,
  output logic [$clog2(SPRITE_SIZE)-1:0] rom_col,
  input  logic [11:0]                    rom_pixel,
  output logic [11:0]                    rgb_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           collision
);

  localparam int AW = $clog2(SPRITE_SIZE);

  logic [XW-1:0] bx, by;
  logic [XW:0]   x_ext, y_ext, x_end, y_end;
  logic          in_box;

  logic          in_box1, video_on1, hsync1, vsync1, pipe_on1;
  logic [11:0]   bg_rgb1;
  logic          opaque, hit1, sticky;

  // Bird position only moves between frames so a sprite is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      bx <= '0;
      by <= '0;
    end else if (frame_start) begin
      bx <= bird_x;
      by <= bird_y;
    end
  end

  // Bounds use one extra bit so a bird near the right/bottom edge cannot wrap.
  always_comb begin
    x_ext  = {1'b0, pix_x};
    y_ext  = {1'b0, pix_y};
    x_end  = {1'b0, bx} + (XW+1)'(SPRITE_SIZE);
    y_end  = {1'b0, by} + (XW+1)'(SPRITE_SIZE);
    in_box = (x_ext >= {1'b0, bx}) && (x_ext < x_end) &&
             (y_ext >= {1'b0, by}) && (y_ext < y_end);
  end

  // Only the low address bits matter, so subtract at ROM width directly.
  assign rom_col = pix_x[AW-1:0] - bx[AW-1:0];
  assign rom_row = pix_y[AW-1:0] - by[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sync registers reset high (idle level) so the output syncs stay
      // inactive while the pipeline refills after reset.
      in_box1   <= 1'b0;
      video_on1 <= 1'b0;
      hsync1    <= 1'b1;
      vsync1    <= 1'b1;
      bg_rgb1   <= '0;
      pipe_on1  <= 1'b0;
    end else begin
      in_box1   <= in_box;
      video_on1 <= video_on;
      hsync1    <= hsync_in;
      vsync1    <= vsync_in;
      bg_rgb1   <= bg_rgb;
      pipe_on1  <= pipe_on;
    end
  end

  assign opaque = (rom_pixel != KEY_RGB);
  assign hit1   = video_on1 && in_box1 && pipe_on1 && opaque;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      if (!video_on1)            rgb_out <= '0;
      else if (in_box1 && opaque) rgb_out <= rom_pixel;
      else                       rgb_out <= bg_rgb1;
      hsync_out <= hsync1;
      vsync_out <= vsync1;
    end
  end

  // The frame_start cycle folds in its own hit so an overlap there is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky    <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= sticky | hit1;
      sticky    <= hit1;
    end else if (hit1) begin
      sticky    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bird_sprite_renderer.sv
// Self-checking bench for bird_sprite_renderer: sprite texels are looked up
// directly from pixel/bird coordinates and compared two clocks later.
module tb_bird_sprite_renderer;

  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y, bird_x, bird_y;
  logic        video_on, hsync_in, vsync_in, frame_start, pipe_on;
  logic [11:0] bg_rgb;
  logic [4:0]  rom_row, rom_col;
  logic [11:0] rom_pixel = '0;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out, collision;

  logic [11:0] rom_mem [32][32];

  bird_sprite_renderer dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .bird_x(bird_x), .bird_y(bird_y), .bg_rgb(bg_rgb), .pipe_on(pipe_on),
    .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .collision(collision)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) rom_pixel <= rom_mem[rom_row][rom_col];

  typedef struct {
    logic [11:0] rgb;
    bit          hs, vs, hit;
  } exp_t;

  typedef struct {
    int          bx, by, x, y;
    bit          vo;
    logic [11:0] exp_rgb;
  } vec_t;

  int   checks = 0, errors = 0;
  int   m_bx, m_by;
  bit   m_sticky, m_coll;
  exp_t p1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_sticky = 0; m_coll = 0;
    p1 = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, hit: 1'b0};
  endtask

  // One pixel clock: drive inputs, predict, clock, compare the outputs due now.
  task automatic cycle(input int x, input int y, input bit vo, input bit hs, input bit vs,
                       input bit fs, input bit pipe, input logic [11:0] bg,
                       input int bxin, input int byin);
    exp_t        e, exp_out;
    bit          inb;
    logic [11:0] tex;
    pix_x = x[9:0]; pix_y = y[9:0]; video_on = vo; hsync_in = hs; vsync_in = vs;
    frame_start = fs; pipe_on = pipe; bg_rgb = bg; bird_x = bxin[9:0]; bird_y = byin[9:0];
    inb   = (x >= m_bx) && (x < m_bx + 32) && (y >= m_by) && (y < m_by + 32);
    tex   = rom_mem[(y - m_by) & 31][(x - m_bx) & 31];
    e.rgb = !vo ? 12'h000 : (inb && tex != KEY) ? tex : bg;
    e.hs  = hs;
    e.vs  = vs;
    e.hit = vo && inb && pipe && (tex != KEY);
    if (fs) begin
      m_coll   = m_sticky | p1.hit;
      m_sticky = p1.hit;
      m_bx     = bxin;
      m_by     = byin;
    end else if (p1.hit) begin
      m_sticky = 1'b1;
    end
    exp_out = p1;
    p1      = e;
    @(posedge clk); #1;
    check("rgb", rgb_out, exp_out.rgb);
    check("hsync", hsync_out, exp_out.hs);
    check("vsync", vsync_out, exp_out.vs);
    check("collision", collision, m_coll);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 1, 0, 0, 12'h00F, m_bx, m_by);
  endtask

  task automatic new_frame(input int bx, input int by);
    cycle(0, 0, 0, 1, 1, 1, 0, 12'h00F, bx, by);
  endtask

  // Show one pixel and check the composited colour two clocks later.
  task automatic probe(input string name, input int x, input int y, input bit pipe,
                       input logic [11:0] exp);
    cycle(x, y, 1, 1, 1, 0, pipe, 12'h00F, m_bx, m_by);
    idle(1);
    check(name, rgb_out, exp);
  endtask

  vec_t vecs[$];

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) rom_mem[r][c] = 12'hFF0;
    rom_mem[0][0] = KEY;
    rom_mem[0][1] = 12'h123;

    vecs = '{
      '{100, 200,  100, 200, 1, 12'h00F},
      '{100, 200,  101, 200, 1, 12'h123},
      '{100, 200,   99, 200, 1, 12'h00F},
      '{100, 200,  132, 200, 1, 12'h00F},
      '{100, 200,  131, 231, 1, 12'hFF0},
      '{100, 200,  131, 232, 1, 12'h00F},
      '{100, 200,  100, 199, 1, 12'h00F},
      '{100, 200,  110, 210, 0, 12'h000},
      '{1000, 200, 1000, 205, 1, 12'hFF0},
      '{1000, 200, 1023, 205, 1, 12'hFF0},
      '{1000, 200,    0, 205, 1, 12'h00F},
      '{1000, 200,    7, 205, 1, 12'h00F},
      '{1000, 200, 1000, 200, 1, 12'h00F}
    };

    rst_n = 1'b0;
    pix_x = '0; pix_y = '0; video_on = 0; hsync_in = 0; vsync_in = 0;
    frame_start = 0; pipe_on = 0; bg_rgb = '0; bird_x = '0; bird_y = '0;
    model_reset();
    #12;
    check("reset_rgb", rgb_out, 12'h000);
    check("reset_hsync", hsync_out, 1'b1);
    check("reset_vsync", vsync_out, 1'b1);
    check("reset_coll", collision, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Placement, transparency and right-edge behaviour.
    foreach (vecs[i]) begin
      if (vecs[i].bx != m_bx || vecs[i].by != m_by) new_frame(vecs[i].bx, vecs[i].by);
      cycle(vecs[i].x, vecs[i].y, vecs[i].vo, 1, 1, 0, 0, 12'h00F, m_bx, m_by);
      idle(1);
      check($sformatf("tbl%0d", i), rgb_out, vecs[i].exp_rgb);
    end

    // Bird position changes take effect only at the next frame_start.
    new_frame(100, 200);
    cycle(110, 210, 1, 1, 1, 0, 0, 12'h00F, 300, 200);
    idle(1);
    check("midframe_old_pos", rgb_out, 12'hFF0);
    new_frame(300, 200);
    probe("newframe_old_pos", 110, 210, 0, 12'h00F);
    probe("newframe_new_pos", 310, 210, 0, 12'hFF0);

    // Collision reported for one frame, then cleared by a clean frame.
    probe("hit_pixel", 310, 210, 1, 12'hFF0);
    idle(3);
    check("coll_before_fs", collision, 1'b0);
    new_frame(300, 200);
    check("coll_set", collision, 1'b1);
    probe("clean_pixel", 310, 210, 0, 12'hFF0);
    new_frame(300, 200);
    check("coll_cleared", collision, 1'b0);
    // Hit whose stage-1 cycle coincides with frame_start.
    cycle(310, 210, 1, 1, 1, 0, 1, 12'h00F, 300, 200);
    new_frame(300, 200);
    check("coll_fs_hit", collision, 1'b1);
    idle(2);
    new_frame(300, 200);
    idle(2);
    new_frame(300, 200);
    check("coll_fs_hit_gone", collision, 1'b0);

    // Mid-line asynchronous reset, then sync delay after release.
    cycle(305, 205, 1, 0, 0, 0, 0, 12'h00F, 300, 200);
    cycle(306, 205, 1, 0, 0, 0, 0, 12'h00F, 300, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", rgb_out, 12'h000);
    check("midrst_hsync", hsync_out, 1'b1);
    check("midrst_vsync", vsync_out, 1'b1);
    check("midrst_coll", collision, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 12'h00F, 0, 0);
    check("rel_hsync_d1", hsync_out, 1'b1);
    cycle(0, 0, 0, 1, 1, 0, 0, 12'h00F, 0, 0);
    check("rel_hsync_d2", hsync_out, 1'b0);
    check("rel_vsync_d2", vsync_out, 1'b0);
    idle(2);

    // Randomised frames against the reference model.
    for (int blk = 0; blk < 6; blk++) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          rom_mem[r][c] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
      new_frame($urandom_range(0, 1023), $urandom_range(0, 1023));
      for (int n = 0; n < 400; n++) begin
        int x, y;
        bit fs;
        x  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023)
                                         : (m_bx + $urandom_range(0, 40) - 4) & 1023;
        y  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023)
                                         : (m_by + $urandom_range(0, 40) - 4) & 1023;
        fs = ($urandom_range(0, 49) == 0);
        cycle(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
              fs, $urandom_range(0, 1), 12'($urandom),
              fs ? $urandom_range(0, 1023) : m_bx, fs ? $urandom_range(0, 1023) : m_by);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
